// File: rtl/sreg_arbiter.sv
// rtl/sreg_arbiter.sv - two-requester arbiter feeding a fixed-latency delay line
// Every stage holds {valid, src, data}; the last stage drives dout directly.
module sreg_arbiter #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  output logic             gnt0,
  output logic             gnt1,
  input  logic             hold,
  input  logic             flush,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             dout_src,
  output logic [3:0]       occ
);

  logic [DEPTH-1:0]            vld;
  logic [DEPTH-1:0]            srcv;
  logic [DEPTH-1:0][WIDTH-1:0] dat;
  logic                        prio;
  logic [3:0]                  occ_q;

  logic                        advance;
  logic                        gnt_any;
  logic [WIDTH-1:0]            gdat;
  logic [DEPTH-1:0]            nvld;
  logic [3:0]                  ncnt;

  assign advance = ~hold & ~flush;

  // Grants are gated by the raw reset so nothing is offered while it is low.
  always_comb begin
    gnt0    = reset & advance & req0 & (~req1 | ~prio);
    gnt1    = reset & advance & req1 & (~req0 | prio);
    gnt_any = gnt0 | gnt1;
    gdat    = gnt0 ? din0 : (gnt1 ? din1 : '0);
    nvld    = {vld[DEPTH-2:0], gnt_any};
    ncnt    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ncnt = ncnt + 4'(nvld[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld   <= '0;
      srcv  <= '0;
      dat   <= '0;
      occ_q <= '0;
      prio  <= 1'b0;
    end else if (flush) begin
      // Flush wins over hold and leaves the fairness pointer untouched.
      vld   <= '0;
      srcv  <= '0;
      dat   <= '0;
      occ_q <= '0;
    end else if (!hold) begin
      vld   <= nvld;
      srcv  <= {srcv[DEPTH-2:0], gnt1};
      dat   <= {dat[DEPTH-2:0], gdat};
      occ_q <= ncnt;
      if (gnt_any) begin
        prio <= gnt0;
      end
    end
  end

  assign dout       = dat[DEPTH-1];
  assign dout_valid = vld[DEPTH-1];
  assign dout_src   = srcv[DEPTH-1];
  assign occ        = occ_q;

endmodule

// File: tb/tb_sreg_arbiter.sv
// tb/tb_sreg_arbiter.sv - scoreboard bench for sreg_arbiter
// Expected words are queued with the edge count at which they must reach dout.
module tb_sreg_arbiter;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0, req1, hold, flush;
  logic [WIDTH-1:0] din0, din1;
  logic             gnt0, gnt1;
  logic [WIDTH-1:0] dout;
  logic             dout_valid, dout_src;
  logic [3:0]       occ;

  sreg_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .din0(din0), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1), .hold(hold), .flush(flush),
    .dout(dout), .dout_valid(dout_valid), .dout_src(dout_src), .occ(occ)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             src;
    logic [WIDTH-1:0] data;
    int               due;
  } ent_t;

  ent_t q[$];
  int   adv;
  logic mprio;
  int   checks;
  int   passed;

  logic [1:0]         exp_gnt, obs_gnt;
  logic [WIDTH+5:0]   exp_out;

  function automatic logic [WIDTH+5:0] obs_out();
    return {dout_valid, dout_src, dout, occ};
  endfunction

  // One clock: drive inputs, sample grants mid-cycle, step the scoreboard after the edge.
  task automatic drive_edge(input logic r0, input logic r1, input logic [WIDTH-1:0] d0,
                            input logic [WIDTH-1:0] d1, input logic h, input logic f);
    ent_t e;
    req0 = r0; req1 = r1; din0 = d0; din1 = d1; hold = h; flush = f;
    exp_gnt[1] = !h && !f && r0 && (!r1 || !mprio);
    exp_gnt[0] = !h && !f && r1 && (!r0 || mprio);
    #3;
    obs_gnt = {gnt0, gnt1};
    @(posedge clk);
    #1;
    if (f) begin
      q.delete();
    end else if (!h) begin
      adv++;
      if (exp_gnt != 2'b00) begin
        e.src  = exp_gnt[0];
        e.data = exp_gnt[1] ? d0 : d1;
        e.due  = adv + DEPTH - 1;
        q.push_back(e);
        mprio = exp_gnt[1];
      end
    end
    while (q.size() > 0 && q[0].due < adv) void'(q.pop_front());
    if (q.size() > 0 && q[0].due == adv)
      exp_out = {1'b1, q[0].src, q[0].data, 4'(q.size())};
    else
      exp_out = {1'b0, 1'b0, {WIDTH{1'b0}}, 4'(q.size())};
  endtask

  task automatic test_reset();
    reset = 1'b0; req0 = 1'b1; req1 = 1'b1; din0 = 4'hF; din1 = 4'hF; hold = 1'b0; flush = 1'b0;
    q.delete(); adv = 0; mprio = 1'b0;
    #2;
    checks++;
    if ({gnt0, gnt1} !== 2'b00) $display("FAIL reset_gnt got %b exp 00", {gnt0, gnt1});
    else passed++;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs_out() !== '0) $display("FAIL reset_out got %h exp 0", obs_out());
    else passed++;
    req0 = 1'b0; req1 = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_contention();
    for (int i = 0; i < 10 + DEPTH; i++) begin
      drive_edge(i < 10, i < 10, 4'h3, 4'hC, 1'b0, 1'b0);
      checks++;
      if (obs_gnt !== exp_gnt) $display("FAIL contention_gnt cyc %0d got %b exp %b", i, obs_gnt, exp_gnt);
      else passed++;
      checks++;
      if (obs_out() !== exp_out) $display("FAIL contention_out cyc %0d got %h exp %h", i, obs_out(), exp_out);
      else passed++;
    end
  endtask

  task automatic test_single();
    int seen_at;
    seen_at = -1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive_edge(i == 0, 1'b0, 4'hA, 4'h0, 1'b0, 1'b0);
      if (dout_valid === 1'b1 && seen_at < 0) seen_at = i + 1;
      checks++;
      if (obs_gnt !== exp_gnt) $display("FAIL single_gnt cyc %0d got %b exp %b", i, obs_gnt, exp_gnt);
      else passed++;
      checks++;
      if (obs_out() !== exp_out) $display("FAIL single_out cyc %0d got %h exp %h", i, obs_out(), exp_out);
      else passed++;
    end
    checks++;
    if (seen_at !== DEPTH) $display("FAIL single_latency got %0d exp %0d", seen_at, DEPTH);
    else passed++;
  endtask

  task automatic test_hold();
    logic             rq [10] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    logic             hd [10] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    logic [WIDTH-1:0] wd [10] = '{1, 2, 3, 3, 3, 4, 0, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      drive_edge(1'b0, rq[i], 4'h0, wd[i], hd[i], 1'b0);
      checks++;
      if (obs_gnt !== exp_gnt) $display("FAIL hold_gnt cyc %0d got %b exp %b", i, obs_gnt, exp_gnt);
      else passed++;
      checks++;
      if (obs_out() !== exp_out) $display("FAIL hold_out cyc %0d got %h exp %h", i, obs_out(), exp_out);
      else passed++;
    end
  endtask

  task automatic test_flush();
    logic r0 [12] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    logic r1 [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    logic hd [12] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    logic fl [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      drive_edge(r0[i], r1[i], 4'(i + 5), 4'h9, hd[i], fl[i]);
      checks++;
      if (obs_gnt !== exp_gnt) $display("FAIL flush_gnt cyc %0d got %b exp %b", i, obs_gnt, exp_gnt);
      else passed++;
      checks++;
      if (obs_out() !== exp_out) $display("FAIL flush_out cyc %0d got %h exp %h", i, obs_out(), exp_out);
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) drive_edge(1'b1, 1'b0, 4'(i + 1), 4'h0, 1'b0, 1'b0);
    checks++;
    if (occ !== 4'd4) $display("FAIL async_fill occ got %0d exp 4", occ);
    else passed++;
    #1;
    req0 = 1'b1; reset = 1'b0;
    #1;
    checks++;
    if ({obs_out(), gnt0, gnt1} !== '0) $display("FAIL async_immediate got %h exp 0", {obs_out(), gnt0, gnt1});
    else passed++;
    req0 = 1'b0;
    q.delete(); mprio = 1'b0;
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    adv++;
    checks++;
    if (obs_out() !== '0) $display("FAIL async_after got %h exp 0", obs_out());
    else passed++;
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive_edge(1'b0, i == 0, 4'h0, 4'h5, 1'b0, 1'b0);
      checks++;
      if (obs_gnt !== exp_gnt) $display("FAIL async_gnt cyc %0d got %b exp %b", i, obs_gnt, exp_gnt);
      else passed++;
      checks++;
      if (obs_out() !== exp_out) $display("FAIL async_out cyc %0d got %h exp %h", i, obs_out(), exp_out);
      else passed++;
    end
  endtask

  task automatic test_random();
    logic r0, r1, h, f;
    for (int i = 0; i < 160; i++) begin
      r0 = $urandom_range(0, 1);
      r1 = $urandom_range(0, 1);
      h  = (i < 150) && ($urandom_range(0, 3) == 0);
      f  = (i < 150) && ($urandom_range(0, 15) == 0);
      drive_edge(r0 && i < 150, r1 && i < 150, 4'($urandom), 4'($urandom), h, f);
      checks++;
      if (obs_gnt !== exp_gnt) $display("FAIL random_gnt cyc %0d got %b exp %b", i, obs_gnt, exp_gnt);
      else passed++;
      checks++;
      if (obs_out() !== exp_out) $display("FAIL random_out cyc %0d got %h exp %h", i, obs_out(), exp_out);
      else passed++;
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_contention();
    test_single();
    test_hold();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
